// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer: FSM states, memory op codes,
// register address width and active-low enable levels.
package pipe_ctrl_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int MEM_OP_W   = 2;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [MEM_OP_W-1:0]   mem_op_t;

  localparam mem_op_t MEM_OP_NOP = 2'd0;
  localparam mem_op_t MEM_OP_LDW = 2'd1;
  localparam mem_op_t MEM_OP_STW = 2'd2;

  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  typedef enum logic [1:0] {
    PC_RUN  = 2'd0,
    PC_WAIT = 2'd1,
    PC_ERR  = 2'd2
  } pc_state_e;

endpackage

// File: rtl/pipe_ctrl_hazard_det.sv
// Load-use hazard detector: the instruction in ID reads a register that the
// load currently in EX has not yet fetched from memory.
module pipe_ctrl_hazard_det
  import pipe_ctrl_pkg::*;
(
  input  logic      rs1_used,
  input  logic      rs2_used,
  input  reg_addr_t rs1_addr,
  input  reg_addr_t rs2_addr,
  input  logic      id_en,
  input  mem_op_t   id_mem_op,
  input  reg_addr_t id_dst_addr,
  input  logic      id_gpr_we_,
  output logic      load_use
);

  logic [1:0] src_used;
  reg_addr_t  src_addr [2];
  logic [1:0] src_hit;
  logic       load_pending;

  assign src_used    = {rs2_used, rs1_used};
  assign src_addr[0] = rs1_addr;
  assign src_addr[1] = rs2_addr;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      assign src_hit[gi] = src_used[gi] && (src_addr[gi] == id_dst_addr);
    end
  endgenerate

  // r0 is hardwired to zero, so a load targeting it never creates a dependency
  assign load_pending = id_en && (id_mem_op == MEM_OP_LDW) &&
                        (id_gpr_we_ == ENABLE_) && (id_dst_addr != '0);

  assign load_use = load_pending && (|src_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: stall/flush for IF/ID, ID/EX, EX/MEM, MEM/WB registers,
// memory-wait watchdog with bus-error pulse, and a saturating stall counter.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int PERF_W      = 16
) (
  input  logic              clk,
  input  logic              reset_,
  input  reg_addr_t         dec_rs1_addr,
  input  reg_addr_t         dec_rs2_addr,
  input  logic              dec_rs1_used,
  input  logic              dec_rs2_used,
  input  logic              id_en,
  input  mem_op_t           id_mem_op,
  input  reg_addr_t         id_dst_addr,
  input  logic              id_gpr_we_,
  input  logic              br_taken,
  input  logic              exc_req,
  input  logic              mem_busy,
  output logic              if_stall,
  output logic              if_flush,
  output logic              id_stall,
  output logic              id_flush,
  output logic              ex_stall,
  output logic              ex_flush,
  output logic              mem_stall,
  output logic              mem_flush,
  output logic              bus_err,
  output logic [PERF_W-1:0] stall_cycles
);

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  pc_state_e         state_reg;
  logic [7:0]        wait_cnt_reg;
  logic              bus_err_reg;
  logic [PERF_W-1:0] stall_cycles_reg;
  logic              load_use;
  logic [3:0]        stall_vec;
  logic [3:0]        flush_vec;
  logic              any_stall;

  pipe_ctrl_hazard_det u_hazard_det (
    .rs1_used    (dec_rs1_used),
    .rs2_used    (dec_rs2_used),
    .rs1_addr    (dec_rs1_addr),
    .rs2_addr    (dec_rs2_addr),
    .id_en       (id_en),
    .id_mem_op   (id_mem_op),
    .id_dst_addr (id_dst_addr),
    .id_gpr_we_  (id_gpr_we_),
    .load_use    (load_use)
  );

  // Vector bit order: [3]=if, [2]=id, [1]=ex, [0]=mem
  always_comb begin
    stall_vec = 4'b0000;
    flush_vec = 4'b0000;
    if (!reset_) begin
      flush_vec = 4'b1111;
    end else if (state_reg == PC_ERR || exc_req) begin
      flush_vec = 4'b1111;
    end else if (mem_busy) begin
      stall_vec = 4'b1111;
    end else if (br_taken) begin
      flush_vec = 4'b1100;
    end else if (load_use) begin
      stall_vec = 4'b1000;
      flush_vec = 4'b0100;
    end
  end

  assign {if_stall, id_stall, ex_stall, mem_stall} = stall_vec;
  assign {if_flush, id_flush, ex_flush, mem_flush} = flush_vec;
  assign any_stall = |stall_vec;

  // exc_req has no influence here: the watchdog keeps running through flushes
  always_ff @(posedge clk) begin
    if (!reset_) begin
      state_reg    <= PC_RUN;
      wait_cnt_reg <= 8'd0;
      bus_err_reg  <= 1'b0;
    end else begin
      bus_err_reg <= 1'b0;
      case (state_reg)
        PC_RUN: begin
          wait_cnt_reg <= 8'd0;
          if (mem_busy) state_reg <= PC_WAIT;
        end
        PC_WAIT: begin
          if (!mem_busy) begin
            state_reg    <= PC_RUN;
            wait_cnt_reg <= 8'd0;
          end else if (wait_cnt_reg == WAIT_LAST) begin
            state_reg    <= PC_ERR;
            wait_cnt_reg <= 8'd0;
            bus_err_reg  <= 1'b1;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 8'd1;
          end
        end
        default: begin
          state_reg    <= PC_RUN;
          wait_cnt_reg <= 8'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_) begin
      stall_cycles_reg <= '0;
    end else if (any_stall && (stall_cycles_reg != '1)) begin
      stall_cycles_reg <= stall_cycles_reg + 1'b1;
    end
  end

  assign bus_err      = bus_err_reg;
  assign stall_cycles = stall_cycles_reg;

endmodule
